// File: rtl/serial_sub_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // One extra bit so the counter can reach N without wrapping.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/fs.sv
// Combinational one-bit full subtractor.
module fs (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor: LSB-first, one bit per clock, valid/ready handshakes.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] diff,
  output logic         bout
);

  localparam int unsigned CntW = cnt_width(N);

  state_e          state_q;
  logic [N-1:0]    a_q;
  logic [N-1:0]    b_q;
  logic [N-1:0]    dsh_q;
  logic [N-1:0]    diff_q;
  logic            br_q;
  logic            bout_q;
  logic [CntW-1:0] cnt_q;

  logic            d_bit;
  logic            br_next;

  fs u_fs (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .bin  (br_q),
    .d    (d_bit),
    .bout (br_next)
  );

  // dsh_q collects bits during RUN; diff_q only changes when a result completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      dsh_q   <= '0;
      diff_q  <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            br_q    <= bin;
            cnt_q   <= '0;
            state_q <= StRun;
          end
        end
        StRun: begin
          dsh_q <= {d_bit, dsh_q[N-1:1]};
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          br_q  <= br_next;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CntW'(N - 1)) begin
            diff_q  <= {d_bit, dsh_q[N-1:1]};
            bout_q  <= br_next;
            state_q <= StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign diff      = diff_q;
  assign bout      = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor with N=4.
module tb_serial_subtractor;

  localparam int unsigned N = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic         bin = 1'b0;
  logic         in_ready;
  logic         out_valid;
  logic [N-1:0] diff;
  logic         bout;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int acc_cyc = 0;

  serial_subtractor #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [N-1:0] ta, input logic [N-1:0] tb, input logic tbin,
                        input string tag);
    int k;
    k = 0;
    while (!in_ready && k < 20) begin
      tick();
      k++;
    end
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    a        = ta;
    b        = tb;
    bin      = tbin;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    acc_cyc  = cyc;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic finish_op(input logic [N-1:0] ed, input logic eb, input int exp_lat,
                           input string tag);
    int lat;
    wait_done(lat);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_diff"}, 32'(diff), 32'(ed));
    chk({tag, "_bout"}, 32'(bout), 32'(eb));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_back_idle"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int           lat;
    int           prev_acc;
    logic [8:0]   j;
    logic [N:0]   model;

    // Reset values before any clock edge
    #2;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_bout", 32'(bout), 32'd0);
    #10 rst_n = 1'b1;
    tick();

    // 5 - 3 - 0
    accept(4'd5, 4'd3, 1'b0, "t5m3");
    chk("t5m3_run_in_ready", 32'(in_ready), 32'd0);
    chk("t5m3_run_out_valid", 32'(out_valid), 32'd0);
    finish_op(4'd2, 1'b0, 4, "t5m3");

    accept(4'd3, 4'd5, 1'b0, "t3m5");
    finish_op(4'd14, 1'b1, 4, "t3m5");

    accept(4'd0, 4'd0, 1'b1, "t0m0b");
    finish_op(4'd15, 1'b1, 4, "t0m0b");

    accept(4'd15, 4'd15, 1'b0, "t15m15");
    finish_op(4'd0, 1'b0, 4, "t15m15");

    accept(4'd15, 4'd0, 1'b0, "t15m0");
    finish_op(4'd15, 1'b0, 4, "t15m0");

    // Operand changes and in_valid/out_ready pulses during RUN must be ignored
    accept(4'd6, 4'd2, 1'b0, "tign");
    a         = 4'd1;
    b         = 4'd15;
    bin       = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("tign_still_run", 32'(out_valid), 32'd0);
    finish_op(4'd4, 1'b0, 3, "tign");

    // Hold DONE with out_ready low for 10 cycles while new operands are offered
    accept(4'd12, 4'd7, 1'b1, "thold");
    wait_done(lat);
    chk("thold_lat", 32'(lat), 32'd4);
    for (int i = 0; i < 10; i++) begin
      a        = 4'd3;
      b        = 4'd3;
      in_valid = 1'b1;
      tick();
      chk("thold_diff", 32'(diff), 32'd4);
      chk("thold_bout", 32'(bout), 32'd0);
      chk("thold_in_ready", 32'(in_ready), 32'd0);
      chk("thold_out_valid", 32'(out_valid), 32'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("thold_release", 32'(in_ready), 32'd1);
    chk("thold_keep_diff", 32'(diff), 32'd4);

    // Reset mid-RUN: immediate clear, no result
    accept(4'd15, 4'd1, 1'b0, "trst");
    tick();
    chk("trst_prev_diff_kept", 32'(diff), 32'd4);
    #2 rst_n = 1'b0;
    #1;
    chk("trst_diff", 32'(diff), 32'd0);
    chk("trst_bout", 32'(bout), 32'd0);
    chk("trst_in_ready", 32'(in_ready), 32'd1);
    chk("trst_out_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("trst_no_valid", 32'(out_valid), 32'd0);
    end
    #2 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("trst_after_no_valid", 32'(out_valid), 32'd0);
    end
    accept(4'd9, 4'd4, 1'b0, "t9m4");
    finish_op(4'd5, 1'b0, 4, "t9m4");

    // All 512 combinations back-to-back in a scrambled order
    out_ready = 1'b1;
    prev_acc  = 0;
    for (int i = 0; i < 512; i++) begin
      j     = 9'(i * 37);
      model = {1'b0, j[8:5]} - {1'b0, j[4:1]} - {4'b0000, j[0]};
      accept(j[8:5], j[4:1], j[0], "tall");
      if (i > 0) chk("tall_interval", 32'(acc_cyc - prev_acc), 32'd6);
      prev_acc = acc_cyc;
      wait_done(lat);
      chk("tall_lat", 32'(lat), 32'd4);
      chk("tall_result", 32'({bout, diff}), 32'(model));
      tick();
    end
    out_ready = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter N, default 4: operand width in bits, N >= 2.
REQ-002 clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  operands a, b, bin are valid this cycle.
REQ-005 in_ready  output  1  block can accept new operands.
REQ-006 a  input  N  minuend.
REQ-007 b  input  N  subtrahend.
REQ-008 bin  input  1  borrow-in.
REQ-009 out_valid  output  1  diff and bout hold a completed result.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 diff  output  N  difference, (a - b - bin) mod 2^N.
REQ-012 bout  output  1  borrow-out; 1 when a < b + bin, unsigned.

Function
REQ-013 The block SHALL use a three-state FSM: IDLE, RUN, DONE.
REQ-014 in_ready SHALL be 1 exactly when the state is IDLE; out_valid SHALL be 1 exactly when the state is DONE.
REQ-015 IDLE with in_valid=1 SHALL latch a and b into shift registers, load bin into the borrow flop, clear the bit counter, and enter RUN.
REQ-016 Each RUN cycle SHALL process bit 0 of both shift registers with the current borrow:
- d = a0 ^ b0 ^ br
- br_next = (~a0 & b0) | (~(a0 ^ b0) & br)
- shift d into the MSB of the diff register
- shift both operand registers right by one
- increment the counter
REQ-017 RUN SHALL last exactly N cycles; on the cycle that processes bit N-1, the FSM SHALL go to DONE. The final borrow SHALL be registered as bout.
REQ-018 Latency SHALL be N+1 cycles from the accepting edge to the first cycle with out_valid=1.
REQ-019 In DONE, diff and bout SHALL stay stable until out_ready=1. The FSM SHALL then return to IDLE.
REQ-020 out_ready=0 SHALL hold DONE indefinitely; no new operands are accepted meanwhile.
REQ-021 in_valid during RUN or DONE SHALL be ignored; a, b and bin SHALL be sampled only on the accepting edge.
REQ-022 out_ready outside DONE SHALL have no effect.
REQ-023 diff and bout SHALL keep the last result after leaving DONE, until the next result overwrites them.
REQ-024 The counter SHALL be $clog2(N)+1 bits wide and SHALL never wrap within one operation.
REQ-025 Minimum issue interval SHALL be N+2 cycles: accept, N RUN cycles, DONE with out_ready=1, back in IDLE.

Reset
REQ-026 rst_n=0 SHALL immediately, without waiting for clk, set:
- state to IDLE
- counter, borrow flop, operand registers, diff and bout to 0
REQ-027 During reset, in_ready SHALL read 1 and out_valid SHALL read 0.
REQ-028 Reset asserted mid-RUN or in DONE SHALL abort the operation with no result delivered.
REQ-029 After rst_n deasserts, the first rising edge SHALL act as a normal IDLE cycle.

Structure
REQ-030 A shared package serial_sub_pkg SHALL hold the FSM state enum (IDLE, RUN, DONE) and the counter-width function/constant.
REQ-031 The one-bit datapath SHALL be a sub-module fs, a combinational full subtractor with inputs a, b, bin and outputs d, bout, instantiated once.
REQ-032 The block SHALL have no combinational path from any input to any output except in_ready/out_valid, which decode registered state only.

Verification (N=4)
REQ-033 a=5, b=3, bin=0 -> out_valid on cycle 5 after accept; diff=2, bout=0.
REQ-034 a=3, b=5, bin=0 -> diff=14, bout=1; a=0, b=0, bin=1 -> diff=15, bout=1.
REQ-035 Hold out_ready=0 for 10 cycles in DONE -> diff/bout stable, in_ready=0 throughout; then out_ready=1 -> in_ready=1 the next cycle.
REQ-036 Change a/b and pulse in_valid during RUN -> result still matches the originally accepted operands.
REQ-037 Assert rst_n=0 after 2 RUN cycles -> outputs zero immediately, out_valid never pulses; the next operation a=9, b=4 gives diff=5, bout=0.
REQ-038 Back-to-back random operands with out_ready=1 -> accepts every 6 cycles; diff/bout match the reference model for all 512 (a, b, bin) combinations.
